motor_cmd_dispatcher: RTL and testbench

//  Parametrised successor to the single-slot UART command latch. Parses framed,

---
 rtl/motor_cmd_dispatcher.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_motor_cmd_dispatcher.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_cmd_dispatcher.sv
// Motor command dispatcher: parses framed, checksummed UART commands into
// per-channel FWFT FIFOs and periodically emits a status frame towards UART TX.
module motor_cmd_dispatcher #(
    parameter int unsigned N_CH          = 10,
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned DIV_W         = 15,
    parameter int unsigned STEP_W        = 13,
    parameter int unsigned GAP_TIMEOUT   = 2400,
    parameter int unsigned STATUS_PERIOD = 16384
) (
    input  logic                     CLK_SE_AR,
    input  logic                     rst_n,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic [N_CH-1:0]          ch_valid,
    input  logic [N_CH-1:0]          ch_ready,
    output logic [N_CH*DIV_W-1:0]    ch_divider,
    output logic [N_CH*STEP_W-1:0]   ch_steps,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic [7:0]               err_count
);

    localparam int unsigned CMD_W    = DIV_W + STEP_W;
    localparam int unsigned PL_BYTES = (4 + CMD_W + 7) / 8;
    localparam int unsigned PL_W     = PL_BYTES * 8;
    localparam int unsigned BCNT_W   = $clog2(PL_BYTES + 1);
    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned GAP_W    = $clog2(GAP_TIMEOUT + 1);
    localparam int unsigned TMR_W    = $clog2(STATUS_PERIOD + 1);
    localparam int unsigned NB       = (N_CH + 6) / 7;
    localparam int unsigned MAP_W    = NB * 7;
    localparam int unsigned IDX_W    = $clog2(NB + 1);

    typedef enum logic [1:0] {P_IDLE, P_PAYLOAD, P_CHECK} parserState_e;
    typedef enum logic [1:0] {T_IDLE, T_HDR, T_MAP, T_ERR} txState_e;

    // Parser state
    parserState_e        pState, pStateNext;
    logic [6:0]          chanReg, chanNext;
    logic                flushReg, flushNext;
    logic [7:0]          chkAcc, chkNext;
    logic [BCNT_W-1:0]   byteCnt, byteCntNext;
    logic [PL_W-1:0]     payload, payloadNext;
    logic [GAP_W-1:0]    gapCnt, gapNext;
    logic                commit, gapDrop;

    // Commit decode
    logic                chkOk, chanOk, frameOk, pushFullDrop, dropEv;
    logic [N_CH-1:0]     pushEn, popEn, flushEn, fullC, chValidInt;
    logic [CMD_W-1:0]    cmdEntry;

    // Channel FIFOs
    logic [CMD_W-1:0]    fifoMem [N_CH][DEPTH];
    logic [PTR_W-1:0]    wrPtr   [N_CH];
    logic [PTR_W-1:0]    rdPtr   [N_CH];
    logic [CNT_W-1:0]    fifoCnt [N_CH];

    // Status path
    logic [TMR_W-1:0]    statusTimer;
    logic                statusReq, txStart, txErrAccept;
    txState_e            tState, tStateNext;
    logic [7:0]          txDataNext;
    logic                txValidNext;
    logic [IDX_W-1:0]    mapIdx, mapIdxNext;
    logic [MAP_W-1:0]    mapSnap, mapSnapNext;
    logic [7:0]          errSnap, errSnapNext;

    // Bitmap byte idx of a snapshot; bit7 marks the last bitmap byte
    function automatic logic [7:0] mapByte(input logic [IDX_W-1:0] idx, input logic [MAP_W-1:0] snap);
        logic [MAP_W-1:0] sh;
        sh = snap >> (int'(idx) * 7);
        return {(int'(idx) == int'(NB) - 1), sh[6:0]};
    endfunction

    // Parser state register
    always_ff @(posedge CLK_SE_AR) begin
        if (!rst_n) begin
            pState   <= P_IDLE;
            chanReg  <= '0;
            flushReg <= 1'b0;
            chkAcc   <= '0;
            byteCnt  <= '0;
            payload  <= '0;
            gapCnt   <= '0;
        end else begin
            pState   <= pStateNext;
            chanReg  <= chanNext;
            flushReg <= flushNext;
            chkAcc   <= chkNext;
            byteCnt  <= byteCntNext;
            payload  <= payloadNext;
            gapCnt   <= gapNext;
        end
    end

    // Parser next state: header, little-endian payload shift-in, checksum, gap watchdog
    always_comb begin
        pStateNext  = pState;
        chanNext    = chanReg;
        flushNext   = flushReg;
        chkNext     = chkAcc;
        byteCntNext = byteCnt;
        payloadNext = payload;
        gapNext     = gapCnt;
        commit      = 1'b0;
        gapDrop     = 1'b0;
        if (pState != P_IDLE) begin
            if (rx_valid) begin
                gapNext = '0;
            end else if (gapCnt == GAP_W'(GAP_TIMEOUT - 1)) begin
                gapDrop    = 1'b1;
                pStateNext = P_IDLE;
                gapNext    = '0;
            end else begin
                gapNext = gapCnt + GAP_W'(1);
            end
        end
        if (rx_valid) begin
            case (pState)
                P_IDLE: begin
                    chanNext    = rx_data[6:0];
                    flushNext   = rx_data[7];
                    chkNext     = rx_data;
                    byteCntNext = '0;
                    gapNext     = '0;
                    pStateNext  = rx_data[7] ? P_CHECK : P_PAYLOAD;
                end
                P_PAYLOAD: begin
                    chkNext     = chkAcc ^ rx_data;
                    payloadNext = PL_W'({rx_data, payload} >> 8);
                    byteCntNext = byteCnt + BCNT_W'(1);
                    if (byteCnt == BCNT_W'(PL_BYTES - 1)) begin
                        pStateNext = P_CHECK;
                    end
                end
                P_CHECK: begin
                    commit     = 1'b1;
                    pStateNext = P_IDLE;
                end
                default: pStateNext = P_IDLE;
            endcase
        end
    end

    // FIFO status flags and head presentation
    always_comb begin
        ch_divider = '0;
        ch_steps   = '0;
        for (int c = 0; c < int'(N_CH); c++) begin
            chValidInt[c] = (fifoCnt[c] != '0);
            fullC[c]      = (fifoCnt[c] == CNT_W'(DEPTH));
            ch_divider[c*DIV_W +: DIV_W] = fifoMem[c][rdPtr[c]][DIV_W-1:0];
            ch_steps[c*STEP_W +: STEP_W] = fifoMem[c][rdPtr[c]][CMD_W-1:DIV_W];
        end
    end

    assign ch_valid = chValidInt;

    // Commit decode: push / flush / drop per channel
    always_comb begin
        cmdEntry     = payload[CMD_W+3:4];
        chkOk        = (rx_data == chkAcc);
        chanOk       = (32'(chanReg) < N_CH);
        frameOk      = commit & chkOk & chanOk;
        pushFullDrop = 1'b0;
        for (int c = 0; c < int'(N_CH); c++) begin
            popEn[c]   = chValidInt[c] & ch_ready[c];
            pushEn[c]  = frameOk & ~flushReg & (chanReg == 7'(c)) & (~fullC[c] | popEn[c]);
            flushEn[c] = frameOk & flushReg & (chanReg == 7'(c));
            if (frameOk && !flushReg && (chanReg == 7'(c)) && fullC[c] && !popEn[c]) begin
                pushFullDrop = 1'b1;
            end
        end
        dropEv = gapDrop | (commit & ~(chkOk & chanOk)) | pushFullDrop;
    end

    // Channel FIFO storage and pointers; flush overrides a coincident pop
    always_ff @(posedge CLK_SE_AR) begin
        if (!rst_n) begin
            for (int c = 0; c < int'(N_CH); c++) begin
                wrPtr[c]   <= '0;
                rdPtr[c]   <= '0;
                fifoCnt[c] <= '0;
                for (int d = 0; d < int'(DEPTH); d++) begin
                    fifoMem[c][d] <= '0;
                end
            end
        end else begin
            for (int c = 0; c < int'(N_CH); c++) begin
                if (flushEn[c]) begin
                    fifoCnt[c] <= '0;
                    rdPtr[c]   <= wrPtr[c];
                end else begin
                    if (pushEn[c]) begin
                        fifoMem[c][wrPtr[c]] <= cmdEntry;
                        wrPtr[c] <= wrPtr[c] + PTR_W'(1);
                    end
                    if (popEn[c]) begin
                        rdPtr[c] <= rdPtr[c] + PTR_W'(1);
                    end
                    if (pushEn[c] && !popEn[c]) begin
                        fifoCnt[c] <= fifoCnt[c] + CNT_W'(1);
                    end else if (!pushEn[c] && popEn[c]) begin
                        fifoCnt[c] <= fifoCnt[c] - CNT_W'(1);
                    end
                end
            end
        end
    end

    // Saturating drop counter, cleared when the status frame delivers it
    always_ff @(posedge CLK_SE_AR) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (txErrAccept) begin
            err_count <= dropEv ? 8'd1 : 8'd0;
        end else if (dropEv && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end

    // Free-running status timer raising a frame request at each wrap
    always_ff @(posedge CLK_SE_AR) begin
        if (!rst_n) begin
            statusTimer <= '0;
            statusReq   <= 1'b0;
        end else begin
            if (statusTimer == TMR_W'(STATUS_PERIOD - 1)) begin
                statusTimer <= '0;
                statusReq   <= 1'b1;
            end else begin
                statusTimer <= statusTimer + TMR_W'(1);
                if (txStart) begin
                    statusReq <= 1'b0;
                end
            end
        end
    end

    // TX FSM state register
    always_ff @(posedge CLK_SE_AR) begin
        if (!rst_n) begin
            tState   <= T_IDLE;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            mapIdx   <= '0;
            mapSnap  <= '0;
            errSnap  <= '0;
        end else begin
            tState   <= tStateNext;
            tx_data  <= txDataNext;
            tx_valid <= txValidNext;
            mapIdx   <= mapIdxNext;
            mapSnap  <= mapSnapNext;
            errSnap  <= errSnapNext;
        end
    end

    // TX FSM next state: header, bitmap bytes, error count; advance on acceptance
    always_comb begin
        tStateNext  = tState;
        txDataNext  = tx_data;
        txValidNext = tx_valid;
        mapIdxNext  = mapIdx;
        mapSnapNext = mapSnap;
        errSnapNext = errSnap;
        txStart     = 1'b0;
        txErrAccept = 1'b0;
        case (tState)
            T_IDLE: begin
                if (statusReq) begin
                    txStart     = 1'b1;
                    txDataNext  = 8'hA5;
                    txValidNext = 1'b1;
                    errSnapNext = err_count;
                    mapSnapNext = '0;
                    for (int c = 0; c < int'(N_CH); c++) begin
                        mapSnapNext[c] = ~fullC[c];
                    end
                    tStateNext = T_HDR;
                end
            end
            T_HDR: begin
                if (tx_valid && tx_ready) begin
                    mapIdxNext = '0;
                    txDataNext = mapByte('0, mapSnap);
                    tStateNext = T_MAP;
                end
            end
            T_MAP: begin
                if (tx_valid && tx_ready) begin
                    if (int'(mapIdx) == int'(NB) - 1) begin
                        txDataNext = errSnap;
                        tStateNext = T_ERR;
                    end else begin
                        mapIdxNext = mapIdx + IDX_W'(1);
                        txDataNext = mapByte(mapIdx + IDX_W'(1), mapSnap);
                    end
                end
            end
            T_ERR: begin
                if (tx_valid && tx_ready) begin
                    txErrAccept = 1'b1;
                    txValidNext = 1'b0;
                    txDataNext  = '0;
                    tStateNext  = T_IDLE;
                end
            end
            default: tStateNext = T_IDLE;
        endcase
    end

endmodule

// File: tb/tb_motor_cmd_dispatcher.sv
// Directed bench for motor_cmd_dispatcher: table of single frames plus
// hand-written sequences for overflow, resync, flush, status frame and reset.
module tb_motor_cmd_dispatcher;

    logic         CLK_SE_AR = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   rx_data = '0;
    logic         rx_valid = 1'b0;
    logic [9:0]   ch_valid;
    logic [9:0]   ch_ready = '0;
    logic [149:0] ch_divider;
    logic [129:0] ch_steps;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready = 1'b0;
    logic [7:0]   err_count;

    int checks = 0;
    int failures = 0;
    int errModel = 0;

    typedef struct {
        logic [7:0]  hdr;
        logic [31:0] cmd;
        bit          badChk;
        bit          expOk;
        logic [14:0] expDiv;
        logic [12:0] expSteps;
    } vec_t;

    vec_t vecs[7];
    logic [7:0] txExp[4];

    always #5 CLK_SE_AR = ~CLK_SE_AR;

    motor_cmd_dispatcher dut (
        .CLK_SE_AR  (CLK_SE_AR),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .ch_valid   (ch_valid),
        .ch_ready   (ch_ready),
        .ch_divider (ch_divider),
        .ch_steps   (ch_steps),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .err_count  (err_count)
    );

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [14:0] getDiv(input int c);
        return ch_divider[c*15 +: 15];
    endfunction

    function automatic logic [12:0] getSteps(input int c);
        return ch_steps[c*13 +: 13];
    endfunction

    task automatic sendByte(input logic [7:0] b, input int popCh);
        @(negedge CLK_SE_AR);
        rx_data  = b;
        rx_valid = 1'b1;
        if (popCh >= 0) ch_ready[popCh] = 1'b1;
        @(negedge CLK_SE_AR);
        rx_valid = 1'b0;
        ch_ready = '0;
    endtask

    task automatic sendFrame(input logic [7:0] hdr, input logic [31:0] cmd, input bit badChk, input int popCh);
        logic [7:0] chk;
        logic [7:0] b;
        chk = hdr;
        sendByte(hdr, -1);
        if (!hdr[7]) begin
            for (int i = 0; i < 4; i++) begin
                b = cmd[8*i +: 8];
                chk ^= b;
                sendByte(b, -1);
            end
        end
        if (badChk) chk ^= 8'h5A;
        sendByte(chk, popCh);
    endtask

    task automatic popCh(input int c);
        @(negedge CLK_SE_AR);
        ch_ready[c] = 1'b1;
        @(negedge CLK_SE_AR);
        ch_ready = '0;
    endtask

    task automatic doReset();
        @(negedge CLK_SE_AR);
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        ch_ready = '0;
        tx_ready = 1'b0;
        repeat (2) @(negedge CLK_SE_AR);
        rst_n    = 1'b1;
        errModel = 0;
    endtask

    task automatic waitTx(output bit ok);
        int n;
        n = 0;
        while (!tx_valid && n < 20000) begin
            @(negedge CLK_SE_AR);
            n++;
        end
        ok = tx_valid;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL tx_wait: tx_valid=%0b after %0d cycles, expected 1", tx_valid, n);
        end
    endtask

    initial begin
        bit ok;
        int ch;
        logic [14:0] headExp[4];

        vecs[0] = '{hdr:8'h03, cmd:32'h00080035, badChk:1'b0, expOk:1'b1, expDiv:15'h0003, expSteps:13'h0001};
        vecs[1] = '{hdr:8'h00, cmd:32'hFFFFFFFF, badChk:1'b0, expOk:1'b1, expDiv:15'h7FFF, expSteps:13'h1FFF};
        vecs[2] = '{hdr:8'h09, cmd:32'h12345678, badChk:1'b0, expOk:1'b1, expDiv:15'h4567, expSteps:13'h0246};
        vecs[3] = '{hdr:8'h0A, cmd:32'h00000100, badChk:1'b0, expOk:1'b0, expDiv:15'h0000, expSteps:13'h0000};
        vecs[4] = '{hdr:8'h05, cmd:32'h0000000F, badChk:1'b0, expOk:1'b1, expDiv:15'h0000, expSteps:13'h0000};
        vecs[5] = '{hdr:8'h06, cmd:32'h00000200, badChk:1'b1, expOk:1'b0, expDiv:15'h0000, expSteps:13'h0000};
        vecs[6] = '{hdr:8'h7F, cmd:32'h00000300, badChk:1'b0, expOk:1'b0, expDiv:15'h0000, expSteps:13'h0000};
        txExp = '{8'hA5, 8'h7B, 8'h87, 8'h01};

        // Reset values
        repeat (3) @(negedge CLK_SE_AR);
        check("rst_ch_valid", ch_valid, 0);
        check("rst_div", ch_divider, 0);
        check("rst_steps", ch_steps, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_err", err_count, 0);
        rst_n = 1'b1;

        // Literal frame to channel 3
        sendByte(8'h03, -1); sendByte(8'h35, -1); sendByte(8'h00, -1);
        sendByte(8'h08, -1); sendByte(8'h00, -1); sendByte(8'h3E, -1);
        check("lit_valid", ch_valid, 10'b0000001000);
        check("lit_div", getDiv(3), 15'h3);
        check("lit_steps", getSteps(3), 13'h1);
        popCh(3);
        check("lit_pop", ch_valid, 0);

        // Table of single frames
        for (int i = 0; i < 7; i++) begin
            ch = int'(vecs[i].hdr[6:0]);
            sendFrame(vecs[i].hdr, vecs[i].cmd, vecs[i].badChk, -1);
            if (vecs[i].expOk) begin
                check($sformatf("vec%0d_valid", i), ch_valid[ch], 1);
                check($sformatf("vec%0d_div", i), getDiv(ch), vecs[i].expDiv);
                check($sformatf("vec%0d_steps", i), getSteps(ch), vecs[i].expSteps);
                popCh(ch);
            end else begin
                errModel++;
            end
            check($sformatf("vec%0d_empty", i), ch_valid, 0);
            check($sformatf("vec%0d_err", i), err_count, errModel);
        end

        // Overflow of channel 0, then push+pop while full
        doReset();
        for (int i = 1; i <= 5; i++) sendFrame(8'h00, 32'(i) << 4, 1'b0, -1);
        check("ovf_err", err_count, 1);
        check("ovf_head", getDiv(0), 15'd1);
        sendFrame(8'h00, 32'h60, 1'b0, 0);
        check("fullpp_err", err_count, 1);
        headExp = '{15'd2, 15'd3, 15'd4, 15'd6};
        for (int k = 0; k < 4; k++) begin
            check($sformatf("fullpp_valid%0d", k), ch_valid[0], 1);
            check($sformatf("fullpp_head%0d", k), getDiv(0), headExp[k]);
            popCh(0);
        end
        check("fullpp_empty", ch_valid, 0);

        // Bad checksum, bad channel, inter-byte gap, then resync
        doReset();
        sendFrame(8'h01, 32'h00000110, 1'b1, -1);
        check("badchk_err", err_count, 1);
        sendFrame(8'h7F, 32'h00000110, 1'b0, -1);
        check("badch_err", err_count, 2);
        sendByte(8'h02, -1); sendByte(8'h35, -1); sendByte(8'h00, -1);
        repeat (3000) @(negedge CLK_SE_AR);
        check("gap_err", err_count, 3);
        check("gap_empty", ch_valid, 0);
        sendFrame(8'h02, 32'h00080035, 1'b0, -1);
        check("resync_valid", ch_valid, 10'b0000000100);
        check("resync_div", getDiv(2), 15'h3);
        check("resync_steps", getSteps(2), 13'h1);
        check("resync_err", err_count, 3);

        // Flush coincident with pop on channel 5
        doReset();
        for (int i = 1; i <= 3; i++) sendFrame(8'h05, 32'(i) << 4, 1'b0, -1);
        check("fl_pre_valid", ch_valid[5], 1);
        sendByte(8'h85, -1);
        sendByte(8'h85, 5);
        check("fl_valid", ch_valid[5], 0);
        check("fl_err", err_count, 0);
        sendFrame(8'h05, 32'h70, 1'b0, -1);
        check("fl_new_valid", ch_valid[5], 1);
        check("fl_new_div", getDiv(5), 15'd7);

        // Status frame with channel 2 full and a stalled TX
        doReset();
        for (int i = 1; i <= 4; i++) sendFrame(8'h02, 32'(i) << 4, 1'b0, -1);
        sendFrame(8'h01, 32'h10, 1'b1, -1);
        check("st_pre_err", err_count, 1);
        waitTx(ok);
        for (int b = 0; b < 4; b++) begin
            check($sformatf("st_valid%0d", b), tx_valid, 1);
            check($sformatf("st_byte%0d", b), tx_data, txExp[b]);
            for (int s = 0; s < 5; s++) begin
                @(negedge CLK_SE_AR);
                check($sformatf("st_hold%0d", b), {tx_valid, tx_data}, {1'b1, txExp[b]});
            end
            tx_ready = 1'b1;
            @(negedge CLK_SE_AR);
            tx_ready = 1'b0;
        end
        check("st_done", tx_valid, 0);
        check("st_err_clr", err_count, 0);

        // Reset mid-payload and mid-status-frame
        doReset();
        waitTx(ok);
        tx_ready = 1'b1;
        @(negedge CLK_SE_AR);
        tx_ready = 1'b0;
        sendFrame(8'h01, 32'h00000550, 1'b0, -1);
        sendFrame(8'h03, 32'h00000550, 1'b1, -1);
        sendByte(8'h04, -1); sendByte(8'h11, -1); sendByte(8'h22, -1);
        @(negedge CLK_SE_AR);
        rst_n = 1'b0;
        @(negedge CLK_SE_AR);
        check("mr_ch_valid", ch_valid, 0);
        check("mr_div", ch_divider, 0);
        check("mr_steps", ch_steps, 0);
        check("mr_tx_valid", tx_valid, 0);
        check("mr_tx_data", tx_data, 0);
        check("mr_err", err_count, 0);
        rst_n = 1'b1;
        sendFrame(8'h04, 32'h00080035, 1'b0, -1);
        check("mr_new_valid", ch_valid, 10'b0000010000);
        check("mr_new_div", getDiv(4), 15'h3);
        check("mr_new_steps", getSteps(4), 13'h1);
        check("mr_new_err", err_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
